ram_word_port: RTL and testbench

Parametrised byte-RAM word access engine, the successor to the fixed 4-byte read and write helpers used by the command state machine. It serves one start/done request at a time. A read gathers 1..WORD_BYTES consecutive bytes from a byte-wide RAM into a word; a write scatters a word into the RAM. Byte order is selectable per request, the RAM read latency is configurable, and addresses wrap. It sits between the command state machine and the on-chip buffer RAM.

---
 rtl/ram_word_port_pkg.sv | 24 ++
 rtl/ram_word_port_if.sv | 33 +++
 rtl/ram_word_port_rd_valid_pipe.sv | 49 ++++
 rtl/ram_word_port.sv | 217 +++++++++++++++++++++
 tb/tb_ram_word_port.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_word_port_pkg.sv
// Shared types and helpers for the byte-RAM word access engine.
//   state_e        : engine state encoding
//   lane_of()      : maps byte index k of an nbytes request to its word lane
//   MAX_RD_LATENCY : deepest RAM read latency the engine supports
package ram_word_port_pkg;

    localparam int unsigned MAX_RD_LATENCY = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        WR,
        FINISH
    } state_e;

    // Little-endian: byte k in lane k; big-endian: byte k in lane n-1-k.
    function automatic int unsigned lane_of(input int unsigned k,
                                            input int unsigned n,
                                            input logic        big_endian);
        return big_endian ? (n - 1 - k) : k;
    endfunction

endpackage

// File: rtl/ram_word_port_if.sv
// Request/response bus between the command state machine and the word engine.
//   start/wr_mode/addr/nbytes/big_endian/wr_word : request, sampled with start
//   rd_word/done/err/busy                        : engine response
interface ram_word_port_if #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned ADDR_W     = 8
) ();

    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned CNT_W  = $clog2(WORD_BYTES + 1);

    logic              start;
    logic              wr_mode;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  nbytes;
    logic              big_endian;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              done;
    logic              err;
    logic              busy;

    modport master (
        output start, wr_mode, addr, nbytes, big_endian, wr_word,
        input  rd_word, done, err, busy
    );

    modport slave (
        input  start, wr_mode, addr, nbytes, big_endian, wr_word,
        output rd_word, done, err, busy
    );

endinterface

// File: rtl/ram_word_port_rd_valid_pipe.sv
// Tracks RAM reads in flight: a valid bit plus byte index per stage.
//   clk, reset         : clock, synchronous active-high reset (flushes pipe)
//   in_valid, in_k     : read issued this cycle and its byte index
//   out_valid, out_k   : read whose data is on ram_rd_data this cycle
module rd_valid_pipe #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned K_W        = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [K_W-1:0] in_k,
    output logic           out_valid,
    output logic [K_W-1:0] out_k
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] vld_d;
    logic [K_W-1:0]        k_q [RD_LATENCY];
    logic [K_W-1:0]        k_d [RD_LATENCY];

    // Shift one stage per cycle; stage 0 takes the read issued this cycle.
    always_comb begin
        vld_d    = vld_q;
        k_d      = k_q;
        vld_d[0] = in_valid;
        k_d[0]   = in_k;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            k_d[i]   = k_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                k_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            k_q   <= k_d;
        end
    end

    assign out_valid = vld_q[RD_LATENCY-1];
    assign out_k     = k_q[RD_LATENCY-1];

endmodule

// File: rtl/ram_word_port.sv
// Byte-RAM word access engine: gathers 1..WORD_BYTES bytes into a word or
// scatters a word into the RAM, one request at a time, with per-request
// byte order and wrapping addresses.
//   clk, reset      : clock, synchronous active-high reset
//   req             : request/response bus (slave side)
//   ram_addr        : RAM byte address
//   ram_rd_en       : RAM read strobe, data returns RD_LATENCY cycles later
//   ram_rd_data     : RAM read data
//   ram_wr_data     : RAM write data
//   ram_we          : RAM write enable
module ram_word_port
    import ram_word_port_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    ram_word_port_if.slave    req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [7:0]        ram_rd_data,
    output logic [7:0]        ram_wr_data,
    output logic              ram_we
);

    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned CNT_W  = $clog2(WORD_BYTES + 1);
    // Out-of-range latencies are clamped into the supported range.
    localparam int unsigned PIPE_DEPTH =
        (RD_LATENCY < 1) ? 1 :
        (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(WORD_BYTES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issue_k_q, issue_k_d;
    logic [CNT_W-1:0]  nbytes_q, nbytes_d;
    logic              be_q, be_d;
    logic [WORD_W-1:0] wr_word_q, wr_word_d;
    logic [WORD_W-1:0] rd_word_q, rd_word_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_rd_en_q, ram_rd_en_d;
    logic [7:0]        ram_wr_data_q, ram_wr_data_d;
    logic              ram_we_q, ram_we_d;

    logic              pipe_valid;
    logic [CNT_W-1:0]  pipe_k;
    int unsigned       cap_lane;
    logic              more_bytes;

    // Select one byte lane of a word.
    function automatic logic [7:0] get_lane(input logic [WORD_W-1:0] w,
                                            input int unsigned       lane);
        logic [7:0] b;
        b = '0;
        for (int unsigned j = 0; j < WORD_BYTES; j++) begin
            if (j == lane) begin
                b = w[8*j +: 8];
            end
        end
        return b;
    endfunction

    rd_valid_pipe #(
        .RD_LATENCY (PIPE_DEPTH),
        .K_W        (CNT_W)
    ) u_rd_valid_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (ram_rd_en_q),
        .in_k      (issue_k_q),
        .out_valid (pipe_valid),
        .out_k     (pipe_k)
    );

    // Next state, request latching, RAM strobes and read-byte capture.
    always_comb begin
        state_d       = state_q;
        issue_k_d     = issue_k_q;
        nbytes_d      = nbytes_q;
        be_d          = be_q;
        wr_word_d     = wr_word_q;
        rd_word_d     = rd_word_q;
        busy_d        = busy_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        ram_rd_en_d   = 1'b0;
        ram_we_d      = 1'b0;
        cap_lane      = lane_of(32'(pipe_k), 32'(nbytes_q), be_q);
        more_bytes    = (issue_k_q + CNT_W'(1)) < nbytes_q;

        // Returning read byte lands in its lane; lanes are only ever set
        // while a read is in flight because rd_word was cleared at accept.
        if (pipe_valid) begin
            for (int unsigned j = 0; j < WORD_BYTES; j++) begin
                if (j == cap_lane) begin
                    rd_word_d[8*j +: 8] = ram_rd_data;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (req.start) begin
                    nbytes_d  = req.nbytes;
                    be_d      = req.big_endian;
                    wr_word_d = req.wr_word;
                    issue_k_d = '0;
                    busy_d    = 1'b1;
                    if (req.nbytes == '0 || req.nbytes > MAX_N) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (req.wr_mode) begin
                        state_d       = WR;
                        ram_we_d      = 1'b1;
                        ram_addr_d    = req.addr;
                        ram_wr_data_d = get_lane(req.wr_word,
                                            lane_of(32'd0, 32'(req.nbytes),
                                                    req.big_endian));
                    end else begin
                        state_d     = RD_ISSUE;
                        ram_rd_en_d = 1'b1;
                        ram_addr_d  = req.addr;
                        rd_word_d   = '0;
                    end
                end
            end
            RD_ISSUE: begin
                if (more_bytes) begin
                    ram_rd_en_d = 1'b1;
                    ram_addr_d  = ram_addr_q + ADDR_W'(1);
                    issue_k_d   = issue_k_q + CNT_W'(1);
                end else begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                // The last byte is the youngest read, so the pipe empties
                // as it is captured.
                if (pipe_valid && pipe_k == nbytes_q - CNT_W'(1)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            WR: begin
                if (more_bytes) begin
                    ram_we_d      = 1'b1;
                    ram_addr_d    = ram_addr_q + ADDR_W'(1);
                    issue_k_d     = issue_k_q + CNT_W'(1);
                    ram_wr_data_d = get_lane(wr_word_q,
                                        lane_of(32'(issue_k_q) + 32'd1,
                                                32'(nbytes_q), be_q));
                end else begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            issue_k_q     <= '0;
            nbytes_q      <= '0;
            be_q          <= 1'b0;
            wr_word_q     <= '0;
            rd_word_q     <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            ram_addr_q    <= '0;
            ram_rd_en_q   <= 1'b0;
            ram_wr_data_q <= '0;
            ram_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_k_q     <= issue_k_d;
            nbytes_q      <= nbytes_d;
            be_q          <= be_d;
            wr_word_q     <= wr_word_d;
            rd_word_q     <= rd_word_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            ram_addr_q    <= ram_addr_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_we_q      <= ram_we_d;
        end
    end

    assign req.rd_word  = rd_word_q;
    assign req.done     = done_q;
    assign req.err      = err_q;
    assign req.busy     = busy_q;
    assign ram_addr     = ram_addr_q;
    assign ram_rd_en    = ram_rd_en_q;
    assign ram_wr_data  = ram_wr_data_q;
    assign ram_we       = ram_we_q;

endmodule

// File: tb/tb_ram_word_port.sv
// Bench for ram_word_port: two instances (read latency 1 and 3) share one
// stimulus stream; each has its own RAM and a request-level reference model.
module tb_ram_word_port;

    localparam int unsigned WB = 4;
    localparam int unsigned AW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        wr_mode;
    logic [7:0]  addr;
    logic [2:0]  nbytes;
    logic        big_endian;
    logic [31:0] wr_word;

    logic [1:0]  done_o;
    logic [1:0]  err_o;
    logic [1:0]  busy_o;
    logic [31:0] rdw_o [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h (cycle %0d)",
                     name, g, act, exp, cyc);
        end
    endtask

    function automatic int lane_tb(input int k, input int n, input bit be);
        return be ? (n - 1 - k) : k;
    endfunction

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0: return 8'h00;
            1: return 8'hAC;
            2: return 8'h00;
            3: return 8'h10;
            default: return 8'(i * 37 + 5);
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int unsigned LAT = (g == 0) ? 1 : 3;

        ram_word_port_if #(.WORD_BYTES(WB), .ADDR_W(AW)) rif ();

        logic [7:0] ram_addr;
        logic [7:0] ram_wr_data;
        logic [7:0] ram_rd_data;
        logic       ram_rd_en;
        logic       ram_we;
        logic [7:0] ram   [256];
        logic [7:0] rpipe [LAT];

        assign rif.start      = start;
        assign rif.wr_mode    = wr_mode;
        assign rif.addr       = addr;
        assign rif.nbytes     = nbytes;
        assign rif.big_endian = big_endian;
        assign rif.wr_word    = wr_word;
        assign done_o[g]      = rif.done;
        assign err_o[g]       = rif.err;
        assign busy_o[g]      = rif.busy;
        assign rdw_o[g]       = rif.rd_word;

        ram_word_port #(
            .WORD_BYTES (WB),
            .ADDR_W     (AW),
            .RD_LATENCY (LAT)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .req         (rif),
            .ram_addr    (ram_addr),
            .ram_rd_en   (ram_rd_en),
            .ram_rd_data (ram_rd_data),
            .ram_wr_data (ram_wr_data),
            .ram_we      (ram_we)
        );

        // Byte RAM with LAT-cycle read pipeline; contents reload on reset.
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
                for (int i = 0; i < int'(LAT); i++) rpipe[i] <= 8'h00;
            end else begin
                if (ram_we) ram[ram_addr] <= ram_wr_data;
                rpipe[0] <= ram_rd_en ? ram[ram_addr] : 8'h5A;
                for (int i = 1; i < int'(LAT); i++) rpipe[i] <= rpipe[i-1];
            end
        end
        assign ram_rd_data = rpipe[LAT-1];

        // Request-level reference model: t counts cycles since acceptance.
        logic [7:0]  mem_m [256];
        bit          armed = 1'b0;
        bit          act = 1'b0;
        bit          was_idle;
        int          t, kind, n, done_t;
        logic [7:0]  a;
        bit          be;
        logic [31:0] w;
        logic [31:0] rdw = '0;
        logic [7:0]  last_addr = '0;
        logic [7:0]  last_wd = '0;
        bit          e_en, e_we, e_done, e_err, e_busy;
        logic [7:0]  e_addr, e_wd;
        logic [31:0] e_rdw;

        always @(negedge clk) begin
            was_idle = !act;
            if (armed) begin
                e_busy = act;
                e_done = act && (t == done_t);
                e_err  = e_done && (kind == 2);
                e_en   = act && kind == 0 && t >= 1 && t <= n;
                e_we   = act && kind == 1 && t >= 1 && t <= n;
                e_addr = (e_en || e_we) ? 8'(a + 8'(t - 1)) : last_addr;
                e_wd   = e_we ? 8'(w >> (8 * lane_tb(t - 1, n, be))) : last_wd;
                if (act && kind == 0) begin
                    e_rdw = '0;
                    for (int k = 0; k < n; k++) begin
                        if (k + 2 + int'(LAT) <= t)
                            e_rdw = e_rdw | (32'(mem_m[8'(a + 8'(k))])
                                             << (8 * lane_tb(k, n, be)));
                    end
                end else begin
                    e_rdw = rdw;
                end

                chk("done",        g, 32'(rif.done),    32'(e_done));
                chk("err",         g, 32'(rif.err),     32'(e_err));
                chk("busy",        g, 32'(rif.busy),    32'(e_busy));
                chk("ram_rd_en",   g, 32'(ram_rd_en),   32'(e_en));
                chk("ram_we",      g, 32'(ram_we),      32'(e_we));
                chk("ram_addr",    g, 32'(ram_addr),    32'(e_addr));
                chk("ram_wr_data", g, 32'(ram_wr_data), 32'(e_wd));
                chk("rd_word",     g, rif.rd_word,      e_rdw);

                if (e_we) mem_m[e_addr] = e_wd;
                if (e_en || e_we) last_addr = e_addr;
                if (e_we) last_wd = e_wd;
                if (act) begin
                    if (t == done_t) begin
                        act = 1'b0;
                        if (kind == 0) rdw = e_rdw;
                    end else begin
                        t++;
                    end
                end
            end

            if (reset) begin
                armed     = 1'b1;
                act       = 1'b0;
                rdw       = '0;
                last_addr = '0;
                last_wd   = '0;
                for (int i = 0; i < 256; i++) mem_m[i] = init_byte(i);
            end else if (armed && was_idle && start) begin
                n    = int'(nbytes);
                kind = (n == 0 || n > int'(WB)) ? 2 : (wr_mode ? 1 : 0);
                a    = addr;
                be   = big_endian;
                w    = wr_word;
                t    = 1;
                act  = 1'b1;
                done_t = (kind == 2) ? 1 : (kind == 1) ? n + 1 : n + int'(LAT) + 1;
            end
        end
    end

    // One request; returns the done cycle (relative to start) per instance.
    task automatic do_req(input logic wm, input logic [7:0] ad, input logic [2:0] nb,
                          input logic b, input logic [31:0] wd,
                          output int dc0, output int dc1,
                          output logic e0, output logic e1);
        @(posedge clk); #1;
        start = 1'b1; wr_mode = wm; addr = ad; nbytes = nb;
        big_endian = b; wr_word = wd;
        dc0 = -1; dc1 = -1; e0 = 1'b0; e1 = 1'b0;
        for (int tt = 0; tt < 40 && (dc0 < 0 || dc1 < 0); tt++) begin
            @(negedge clk);
            if (done_o[0] && dc0 < 0) begin dc0 = tt; e0 = err_o[0]; end
            if (done_o[1] && dc1 < 0) begin dc1 = tt; e1 = err_o[1]; end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("done_seen", 0, 32'(dc0 >= 0), 32'd1);
        chk("done_seen", 1, 32'(dc1 >= 0), 32'd1);
    endtask

    task automatic expect_word(input string name, input logic [31:0] exp);
        chk(name, 0, rdw_o[0], exp);
        chk(name, 1, rdw_o[1], exp);
    endtask

    int         d0, d1, c0, c1;
    logic       e0, e1;
    int unsigned r;

    initial begin
        reset = 1'b1; start = 1'b0; wr_mode = 1'b0; addr = '0;
        nbytes = '0; big_endian = 1'b0; wr_word = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        expect_word("reset_rd_word", 32'h0);
        chk("reset_busy", 0, 32'(busy_o), 32'h0);

        // Little- and big-endian reads of 00,AC,00,10.
        do_req(1'b0, 8'h00, 3'd4, 1'b0, 32'h0, d0, d1, e0, e1);
        expect_word("le_read", 32'h1000AC00);
        chk("le_done_cycle", 0, 32'(d0), 32'd6);
        chk("le_done_cycle", 1, 32'(d1), 32'd8);
        chk("le_err", 0, 32'(e0), 32'd0);
        do_req(1'b0, 8'h00, 3'd4, 1'b1, 32'h0, d0, d1, e0, e1);
        expect_word("be_read", 32'h00AC0010);
        do_req(1'b0, 8'h01, 3'd3, 1'b1, 32'h0, d0, d1, e0, e1);
        expect_word("be_read3", 32'h00AC0010);

        // Rejected requests leave rd_word alone.
        do_req(1'b0, 8'h00, 3'd0, 1'b0, 32'h0, d0, d1, e0, e1);
        chk("rej0_cycle", 0, 32'(d0), 32'd1);
        chk("rej0_err", 1, 32'(e1), 32'd1);
        expect_word("rej0_word", 32'h00AC0010);
        do_req(1'b0, 8'h00, 3'd5, 1'b0, 32'h0, d0, d1, e0, e1);
        chk("rej5_cycle", 1, 32'(d1), 32'd1);
        chk("rej5_err", 0, 32'(e0), 32'd1);

        // Wrapping write, then read it back both ways.
        do_req(1'b1, 8'hFE, 3'd4, 1'b0, 32'hDEADBEEF, d0, d1, e0, e1);
        chk("wr_done_cycle", 0, 32'(d0), 32'd5);
        chk("wr_done_cycle", 1, 32'(d1), 32'd5);
        do_req(1'b0, 8'hFE, 3'd4, 1'b0, 32'h0, d0, d1, e0, e1);
        expect_word("wr_readback_le", 32'hDEADBEEF);
        do_req(1'b0, 8'hFE, 3'd4, 1'b1, 32'h0, d0, d1, e0, e1);
        expect_word("wr_readback_be", 32'hEFBEADDE);

        // Reset in cycle 3 of a read aborts it without a done.
        @(posedge clk); #1;
        start = 1'b1; wr_mode = 1'b0; addr = 8'h00; nbytes = 3'd4; big_endian = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        expect_word("abort_rd_word", 32'h0);
        chk("abort_busy", 0, 32'(busy_o), 32'h0);
        c0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o != 2'b00) c0++;
        end
        chk("abort_no_done", 0, 32'(c0), 32'd0);
        do_req(1'b0, 8'h00, 3'd4, 1'b0, 32'h0, d0, d1, e0, e1);
        chk("post_reset_cycle", 0, 32'(d0), 32'd6);
        chk("post_reset_cycle", 1, 32'(d1), 32'd8);
        expect_word("post_reset_word", 32'h1000AC00);

        // Stray start during a write is dropped.
        @(posedge clk); #1;
        start = 1'b1; wr_mode = 1'b1; addr = 8'h40; nbytes = 3'd4; wr_word = 32'h12345678;
        c0 = 0; c1 = 0;
        for (int tt = 0; tt < 16; tt++) begin
            @(negedge clk);
            if (done_o[0]) c0++;
            if (done_o[1]) c1++;
            @(posedge clk); #1;
            start = (tt == 1);
            if (tt == 1) begin wr_mode = 1'b0; nbytes = 3'd2; end
        end
        chk("stray_done_count", 0, 32'(c0), 32'd1);
        chk("stray_done_count", 1, 32'(c1), 32'd1);
        @(negedge clk);
        chk("stray_busy", 0, 32'(busy_o), 32'h0);

        // Random traffic including stray starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start      = ($urandom % 3 == 0);
            wr_mode    = 1'($urandom % 2);
            addr       = 8'($urandom);
            big_endian = 1'($urandom % 2);
            wr_word    = $urandom;
            r          = $urandom % 10;
            nbytes     = (r < 8) ? 3'(32'd1 + r % 4)
                       : (r == 8) ? 3'd0 : 3'(32'd5 + $urandom % 3);
            reset      = ($urandom % 150 == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        repeat (20) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
